// File: rtl/tt_loader_pkg.sv
// Shared types and constants for the TinyTapeout byte-serial program loader.
package tt_loader_pkg;

  localparam int unsigned LANE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = LANE_W * BYTES_PER_WORD;
  localparam int unsigned PHASE_W        = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } ld_state_e;

endpackage

// File: rtl/tt_strobe_sync.sv
// Synchronizes the asynchronous byte strobe, detects its rising edge and
// delays the data byte by the same depth so the byte seen at strobe rise is presented.
module tt_strobe_sync
  import tt_loader_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              strobe_i,
  input  logic [LANE_W-1:0] byte_i,
  output logic              byte_evt_c,
  output logic [LANE_W-1:0] byte_o
);

  logic [SYNC_STAGES-1:0]             sync_q;
  logic                               edge_q;
  logic [SYNC_STAGES-1:0][LANE_W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      data_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_i};
      edge_q <= sync_q[SYNC_STAGES-1];
      data_q <= {data_q[SYNC_STAGES-2:0], byte_i};
    end
  end

  assign byte_evt_c = sync_q[SYNC_STAGES-1] & ~edge_q;
  assign byte_o     = data_q[SYNC_STAGES-1];

endmodule

// File: rtl/tt_prog_loader.sv
// Assembles strobed bytes little-endian into 32-bit words and writes them to
// instruction memory over a valid/ready port with an auto-incrementing address.
module tt_prog_loader
  import tt_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              clear,
  input  logic [7:0]        byte_in,
  input  logic              strobe_in,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [1:0]        byte_phase,
  output logic              wrap_pulse,
  output logic              err_overrun,
  output logic              err_timeout
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  logic              evt_raw;
  logic              evt;
  logic [LANE_W-1:0] sync_byte;

  ld_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WORD_W-1:0]  data_q, data_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               valid_q, valid_d;
  logic               wrap_q, wrap_d;
  logic               ovr_q, ovr_d;
  logic               tmo_err_q, tmo_err_d;

  tt_strobe_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .strobe_i  (strobe_in),
    .byte_i    (byte_in),
    .byte_evt_c(evt_raw),
    .byte_o    (sync_byte)
  );

  // Disabled chip ignores bytes but the synchronizer keeps tracking the pin.
  assign evt = evt_raw & ena;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    phase_d   = phase_q;
    tmo_d     = tmo_q;
    valid_d   = valid_q;
    wrap_d    = 1'b0;
    ovr_d     = ovr_q;
    tmo_err_d = tmo_err_q;

    if (clear) begin
      state_d   = IDLE;
      addr_d    = '0;
      data_d    = '0;
      phase_d   = '0;
      tmo_d     = '0;
      valid_d   = 1'b0;
      ovr_d     = 1'b0;
      tmo_err_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (evt) begin
            data_d[LANE_W-1:0] = sync_byte;
            phase_d            = PHASE_W'(1);
            tmo_d              = '0;
            state_d            = COLLECT;
          end
        end
        COLLECT: begin
          if (evt) begin
            data_d[32'(phase_q)*LANE_W +: LANE_W] = sync_byte;
            tmo_d = '0;
            if (phase_q == PHASE_W'(BYTES_PER_WORD - 1)) begin
              phase_d = '0;
              valid_d = 1'b1;
              state_d = WRITE;
            end else begin
              phase_d = phase_q + PHASE_W'(1);
            end
          end else if (ena) begin
            // Stalled partial word is abandoned so it never reaches memory.
            if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
              phase_d   = '0;
              data_d    = '0;
              tmo_d     = '0;
              tmo_err_d = 1'b1;
              state_d   = IDLE;
            end else begin
              tmo_d = tmo_q + TMO_W'(1);
            end
          end
        end
        WRITE: begin
          if (evt) begin
            ovr_d = 1'b1;
          end
          if (wr_ready) begin
            valid_d = 1'b0;
            addr_d  = addr_q + ADDR_W'(1);
            wrap_d  = (addr_q == {ADDR_W{1'b1}});
            data_d  = '0;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      phase_q   <= '0;
      tmo_q     <= '0;
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
      ovr_q     <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      phase_q   <= phase_d;
      tmo_q     <= tmo_d;
      valid_q   <= valid_d;
      wrap_q    <= wrap_d;
      ovr_q     <= ovr_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign wr_valid    = valid_q;
  assign wr_addr     = addr_q;
  assign wr_data     = data_q;
  assign byte_phase  = phase_q;
  assign wrap_pulse  = wrap_q;
  assign err_overrun = ovr_q;
  assign err_timeout = tmo_err_q;

endmodule

// File: tb/tb_tt_prog_loader.sv
// Self-checking bench for tt_prog_loader: directed steps with random payloads
// compared against a queue-based model of the expected memory writes.
module tb_tt_prog_loader;

  localparam int unsigned ADDR_W      = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned TIMEOUT     = 255;
  localparam int unsigned NWORDS      = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ena = 1'b1;
  logic              clear = 1'b0;
  logic [7:0]        byte_in = 8'h00;
  logic              strobe_in = 1'b0;
  logic              wr_ready = 1'b1;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [1:0]        byte_phase;
  logic              wrap_pulse;
  logic              err_overrun;
  logic              err_timeout;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [7:0]  part[$];
  int          m_addr = 0;
  int          exp_wraps = 0;
  int          got_wraps = 0;
  int          exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  int          got_addr_q[$];
  logic [31:0] got_data_q[$];

  tt_prog_loader #(
    .ADDR_W     (ADDR_W),
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .clear      (clear),
    .byte_in    (byte_in),
    .strobe_in  (strobe_in),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .byte_phase (byte_phase),
    .wrap_pulse (wrap_pulse),
    .err_overrun(err_overrun),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Record every handshake that the next rising edge will complete.
  always @(negedge clk) begin
    if (rst_n && !clear && wr_valid && wr_ready) begin
      got_addr_q.push_back(int'(wr_addr));
      got_data_q.push_back(wr_data);
    end
    if (rst_n && wrap_pulse) got_wraps++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (ena) begin
      part.push_back(b);
      if (part.size() == 4) begin
        exp_data_q.push_back({part[3], part[2], part[1], part[0]});
        exp_addr_q.push_back(m_addr);
        m_addr = (m_addr + 1) % NWORDS;
        if (m_addr == 0) exp_wraps++;
        part.delete();
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in   = b;
    strobe_in = 1'b1;
    cyc(4);
    strobe_in = 1'b0;
    cyc(6);
    model_byte(b);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic check_writes(input string tag);
    for (int i = 0; i < 100 && got_data_q.size() < exp_data_q.size(); i++) cyc(1);
    cyc(2);
    chk({tag, "_count"}, 32'(got_data_q.size()), 32'(exp_data_q.size()));
    while (got_data_q.size() > 0 && exp_data_q.size() > 0) begin
      chk({tag, "_addr"}, 32'(got_addr_q.pop_front()), 32'(exp_addr_q.pop_front()));
      chk({tag, "_data"}, got_data_q.pop_front(), exp_data_q.pop_front());
    end
    got_addr_q.delete();
    got_data_q.delete();
    exp_addr_q.delete();
    exp_data_q.delete();
    chk({tag, "_wraps"}, 32'(got_wraps), 32'(exp_wraps));
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, 32'(wr_valid), 32'd0);
    chk({tag, "_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_data"}, wr_data, 32'd0);
    chk({tag, "_phase"}, 32'(byte_phase), 32'd0);
    chk({tag, "_wrap"}, 32'(wrap_pulse), 32'd0);
    chk({tag, "_ovr"}, 32'(err_overrun), 32'd0);
    chk({tag, "_tmo"}, 32'(err_timeout), 32'd0);
  endtask

  initial begin
    int          n;
    int          stall_addr;
    logic [7:0]  b;
    logic [31:0] w;

    // Reset state
    cyc(3);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    cyc(2);

    // Basic word assembly and address increment
    send_word(32'h00100513);
    check_writes("word0");
    send_word($urandom);
    check_writes("word1");

    // Back-pressure with an overrun strobe during the stall
    wr_ready = 1'b0;
    send_word(32'hDEADBEEF);
    stall_addr = exp_addr_q[exp_addr_q.size()-1];
    for (int i = 0; i < 20; i++) begin
      if (i == 4) begin
        byte_in   = 8'($urandom);
        strobe_in = 1'b1;
      end
      if (i == 8) strobe_in = 1'b0;
      chk("stall_valid", 32'(wr_valid), 32'd1);
      chk("stall_addr", 32'(wr_addr), 32'(stall_addr));
      chk("stall_data", wr_data, 32'hDEADBEEF);
      cyc(1);
    end
    chk("stall_ovr", 32'(err_overrun), 32'd1);
    chk("stall_nowrite", 32'(got_data_q.size()), 32'd0);
    wr_ready = 1'b1;
    check_writes("stall");

    // Partial word abandoned after TIMEOUT idle cycles
    send_byte(8'hAA);
    byte_in   = 8'hBB;
    strobe_in = 1'b1;
    for (int i = 0; i < 20 && byte_phase != 2'd2; i++) cyc(1);
    chk("tmo_phase2", 32'(byte_phase), 32'd2);
    n = 0;
    while (!err_timeout && n < 400) begin
      cyc(1);
      n++;
      if (n == 2) strobe_in = 1'b0;
    end
    part.delete();
    chk("tmo_cycle", 32'(n), 32'(TIMEOUT));
    chk("tmo_flag", 32'(err_timeout), 32'd1);
    chk("tmo_phase0", 32'(byte_phase), 32'd0);
    chk("tmo_data0", wr_data, 32'd0);
    cyc(40);
    send_word(32'h04030201);
    check_writes("after_tmo");

    // Fill memory past its top to exercise the wrap
    for (int i = 0; i < 14; i++) send_word($urandom);
    check_writes("wrap");

    // Held strobe gives a single byte, then async reset mid-word
    b = 8'($urandom);
    byte_in   = b;
    strobe_in = 1'b1;
    cyc(50);
    strobe_in = 1'b0;
    cyc(6);
    model_byte(b);
    chk("held_phase", 32'(byte_phase), 32'd1);
    chk("held_byte", {24'd0, wr_data[7:0]}, {24'd0, b});
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midword_rst");
    part.delete();
    m_addr = 0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // Disabled loader ignores strobes
    ena = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    chk("ena0_phase", 32'(byte_phase), 32'd0);
    chk("ena0_valid", 32'(wr_valid), 32'd0);
    check_writes("ena0");
    ena = 1'b1;

    // Build up address 5 and both error flags, then clear
    for (int i = 0; i < 5; i++) send_word($urandom);
    check_writes("pre_clear");
    send_byte(8'($urandom));
    cyc(TIMEOUT + 10);
    part.delete();
    chk("pre_clear_tmo", 32'(err_timeout), 32'd1);
    wr_ready = 1'b0;
    w = $urandom;
    send_word(w);
    byte_in   = 8'($urandom);
    strobe_in = 1'b1;
    cyc(4);
    strobe_in = 1'b0;
    cyc(4);
    chk("pre_clear_ovr", 32'(err_overrun), 32'd1);
    chk("pre_clear_addr", 32'(wr_addr), 32'd5);
    chk("pre_clear_valid", 32'(wr_valid), 32'd1);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("clear_ovr", 32'(err_overrun), 32'd0);
    chk("clear_tmo", 32'(err_timeout), 32'd0);
    chk("clear_addr", 32'(wr_addr), 32'd0);
    chk("clear_valid", 32'(wr_valid), 32'd0);
    chk("clear_phase", 32'(byte_phase), 32'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
    m_addr = 0;
    wr_ready = 1'b1;
    cyc(4);
    send_word($urandom);
    check_writes("post_clear");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_prog_loader.md
Name: tt_prog_loader

Overview:
- Upstream byte-serial program loader for the TinyTapeout RISC-V core top.
- Accepts 8-bit bytes from the pad-level bus, qualified by an asynchronous strobe pin (uio_in[0] at chip level).
- Assembles 4 bytes little-endian into 32-bit instruction words and writes them into the core's instruction memory over a valid/ready write port, auto-incrementing the word address.

Parameters:
- ADDR_W, 4, instruction-memory word-address width (2^ADDR_W words)
- SYNC_STAGES, 2, flops in the strobe synchronizer (min 2)
- TIMEOUT, 255, idle cycles inside a partial word before the byte phase is discarded (min 1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  TT enable; low freezes the loader
- clear  in  1  synchronous clear of address, phase and flags
- byte_in  in  8  data byte from ui_in
- strobe_in  in  1  asynchronous byte strobe from uio_in[0]
- wr_valid  out  1  write request to instruction memory
- wr_ready  in  1  memory accepts the write
- wr_addr  out  ADDR_W  word address of the current write
- wr_data  out  32  assembled instruction word
- byte_phase  out  2  bytes held in the current partial word
- wrap_pulse  out  1  one-cycle pulse when the address wraps to 0
- err_overrun  out  1  sticky: strobe received while a write was pending
- err_timeout  out  1  sticky: partial word discarded by timeout

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; state IDLE; sync flops 0; timeout counter 0.
  - A reset mid-word discards the partial word.
- Synchronization:
  - strobe_in passes through SYNC_STAGES flops, then one edge-detect flop.
  - A rising edge = sync output 1 and previous 0, producing a one-cycle byte_evt.
  - byte_in is delayed through a matching SYNC_STAGES-deep register chain, so the captured byte is the value present when the strobe rose.
  - Latency from strobe pin rise to byte capture: SYNC_STAGES+1 clocks.
  - A strobe held high yields exactly one event.
- FSM states:
  - IDLE: byte_phase=0. byte_evt stores the byte into wr_data[7:0], sets phase=1, goes to COLLECT.
  - COLLECT:
    - byte_evt stores the byte into wr_data[8*phase +: 8] and increments phase.
    - On the 4th byte, goes to WRITE with wr_valid=1 on the next cycle.
    - The timeout counter restarts on every byte_evt.
    - If the counter reaches TIMEOUT: phase=0, err_timeout=1, go to IDLE.
  - WRITE:
    - wr_valid held high; wr_addr and wr_data held stable until wr_valid && wr_ready.
    - On handshake: wr_valid=0, wr_addr+=1, go to IDLE.
    - If wr_addr was 2^ADDR_W-1, it wraps to 0 and wrap_pulse=1 for one cycle.
    - byte_evt during WRITE: byte dropped, err_overrun=1. This includes byte_evt in the same cycle as the handshake.
- wr_data is cleared to 0 on entry to IDLE after a handshake or timeout. Unwritten upper bytes of a timed-out word never reach memory.
- ena=0:
  - byte_evt ignored (sync flops keep running); timeout counter frozen.
  - WRITE still completes its handshake.
- clear=1:
  - Next edge: wr_addr=0, phase=0, state IDLE, wr_valid=0, both error flags 0.
  - clear has priority over all events in the same cycle.
- Sticky flags clear only via clear or rst_n.

Decomposition:
- Shared package tt_loader_pkg: FSM state enum (IDLE, COLLECT, WRITE), byte-lane width constant (8), bytes-per-word constant (4).
- Sub-module tt_strobe_sync: parameterised SYNC_STAGES synchronizer plus rising-edge detector with matched data delay chain. Outputs byte_evt and the aligned byte.

Test Plan:
- Four strobes (10-cycle spacing) with bytes 0x13,0x05,0x10,0x00, wr_ready=1 -> one write, wr_addr=0, wr_data=0x00100513; next word goes to wr_addr=1.
- wr_ready=0 for 20 cycles after word 0xDEADBEEF completes -> wr_valid, wr_addr and wr_data stable all 20 cycles. A strobe during the stall sets err_overrun=1 with no extra write; releasing wr_ready gives exactly one write.
- Two strobes (0xAA,0xBB), then 300 idle cycles -> err_timeout=1 at cycle TIMEOUT after the last byte, byte_phase=0. The next 4 bytes 0x01..0x04 write 0x04030201.
- Write 2^ADDR_W=16 words -> the 16th write uses wr_addr=15, wrap_pulse high one cycle, the 17th write uses wr_addr=0.
- Strobe held high 50 cycles, then low -> exactly one byte captured, byte_phase=1. rst_n pulsed low mid-word -> all outputs 0 immediately, byte_phase=0.
- ena=0 with 4 strobes -> no byte captured, no write. clear asserted with err flags set and wr_addr=5 -> flags 0, wr_addr=0 next cycle.
